// File: rtl/ocm_pkg.sv
// Shared types and sizes for the OCM board-row prefetcher.
// Optional feature macro: OCM_PREFETCH_FLIP_EN (board flip).
package ocm_pkg;

  localparam int OCM_ADDR_WIDTH = 10;
  localparam int OCM_DATA_WIDTH = 8;
  localparam int BOARD_DIM      = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } pf_state_t;

  typedef logic [2:0] board_idx_t;

endpackage

// File: rtl/ocm_row_prefetch_if.sv
// OCM VGA-port bundle between the prefetcher and the memory.
// Optional feature macro: OCM_PREFETCH_FLIP_EN (board flip).
interface ocm_row_prefetch_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0] vga_addr;
  logic [DATA_WIDTH-1:0] vga_writein;
  logic                  vga_we;
  logic [DATA_WIDTH-1:0] vga_readout;

  modport master (
    output vga_addr,
    output vga_writein,
    output vga_we,
    input  vga_readout
  );

  modport slave (
    input  vga_addr,
    input  vga_writein,
    input  vga_we,
    output vga_readout
  );

endinterface

// File: rtl/ocm_row_buffer.sv
// Ping-pong row store: writes go to the back bank, the
// registered read comes from the front bank.
module ocm_row_buffer
  import ocm_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  swap,
  input  logic                  we,
  input  board_idx_t            widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  board_idx_t            ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] bank [2][BOARD_DIM];
  logic                  sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      sel   <= 1'b0;
      rdata <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < BOARD_DIM; i++) begin
          bank[b][i] <= '0;
        end
      end
    end else begin
      if (swap) sel <= ~sel;
      if (we) bank[~sel][widx] <= wdata;
      rdata <= bank[sel][ridx];
    end
  end

endmodule

// File: rtl/ocm_row_prefetch.sv
// Blanking-time row prefetcher feeding the pixel lookup path.
// Optional feature macro: OCM_PREFETCH_FLIP_EN (board flip).
module ocm_row_prefetch
  import ocm_pkg::*;
#(
  parameter int ADDR_WIDTH = OCM_ADDR_WIDTH,
  parameter int DATA_WIDTH = OCM_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int ROW_STRIDE = 8
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef OCM_PREFETCH_FLIP_EN
  input  logic                  flip,
`endif
  input  logic                  pf_req,
  input  board_idx_t            pf_row,
  input  logic                  line_start,
  input  board_idx_t            col_sel,
  output logic [DATA_WIDTH-1:0] square_data,
  output logic                  pf_busy,
  output logic                  pf_done,
  output logic                  overrun,
  ocm_row_prefetch_if.master    vga
);

  pf_state_t             state;
  board_idx_t            col;
  board_idx_t            rd_col;
  board_idx_t            req_row;
  board_idx_t            buf_widx;
  logic                  rd_valid;
  logic                  buf_we;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] req_base;

`ifdef OCM_PREFETCH_FLIP_EN
  logic flip_q;
  assign req_row  = flip ? ~pf_row : pf_row;
  assign buf_widx = flip_q ? ~rd_col : rd_col;
`else
  assign req_row  = pf_row;
  assign buf_widx = rd_col;
`endif

  // Truncation to ADDR_WIDTH gives the modulo wrap.
  assign req_base = BASE_ADDR
                  + ADDR_WIDTH'(req_row)
                  * ADDR_WIDTH'(ROW_STRIDE);

  assign pf_busy = (state == ISSUE) || (state == DRAIN);
  assign pf_done = (state == DONE);
  assign buf_we  = rd_valid && !line_start;

  assign vga.vga_we      = 1'b0;
  assign vga.vga_writein = '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      col          <= '0;
      rd_col       <= '0;
      rd_valid     <= 1'b0;
      row_base     <= '0;
      overrun      <= 1'b0;
      vga.vga_addr <= '0;
`ifdef OCM_PREFETCH_FLIP_EN
      flip_q       <= 1'b0;
`endif
    end else begin
      rd_valid <= (state == ISSUE) && !line_start;
      rd_col   <= col;
      if (line_start && pf_busy) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (pf_req) begin
            state        <= ISSUE;
            col          <= '0;
            row_base     <= req_base;
            vga.vga_addr <= req_base;
`ifdef OCM_PREFETCH_FLIP_EN
            flip_q       <= flip;
`endif
          end
        end
        ISSUE: begin
          if (line_start) begin
            state <= IDLE;
          end else if (col == 3'd7) begin
            state <= DRAIN;
          end else begin
            col          <= col + 3'd1;
            vga.vga_addr <= row_base
                          + ADDR_WIDTH'(col)
                          + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          state <= line_start ? IDLE : DONE;
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

  ocm_row_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .swap  (line_start),
    .we    (buf_we),
    .widx  (buf_widx),
    .wdata (vga.vga_readout),
    .ridx  (col_sel),
    .rdata (square_data)
  );

endmodule

// File: tb/tb_ocm_row_prefetch.sv
// Scoreboard bench for ocm_row_prefetch; flip cases run
// only when OCM_PREFETCH_FLIP_EN is defined.
module tb_ocm_row_prefetch;
  import ocm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       pf_req;
  logic       pf_req_b;
  logic       line_start;
  logic       flip;
  board_idx_t pf_row;
  board_idx_t pf_row_b;
  board_idx_t col_sel;
  logic [7:0] sq_a, sq_b;
  logic       busy_a, done_a, ovr_a;
  logic       busy_b, done_b, ovr_b;

  ocm_row_prefetch_if #(.ADDR_WIDTH(10), .DATA_WIDTH(8)) vga_a ();
  ocm_row_prefetch_if #(.ADDR_WIDTH(10), .DATA_WIDTH(8)) vga_b ();

  ocm_row_prefetch #(
    .ADDR_WIDTH(10), .DATA_WIDTH(8),
    .BASE_ADDR(10'h000), .ROW_STRIDE(8)
  ) dut_a (
    .clk(clk), .reset(reset),
`ifdef OCM_PREFETCH_FLIP_EN
    .flip(flip),
`endif
    .pf_req(pf_req), .pf_row(pf_row),
    .line_start(line_start), .col_sel(col_sel),
    .square_data(sq_a), .pf_busy(busy_a),
    .pf_done(done_a), .overrun(ovr_a),
    .vga(vga_a)
  );

  ocm_row_prefetch #(
    .ADDR_WIDTH(10), .DATA_WIDTH(8),
    .BASE_ADDR(10'h3FC), .ROW_STRIDE(8)
  ) dut_b (
    .clk(clk), .reset(reset),
`ifdef OCM_PREFETCH_FLIP_EN
    .flip(1'b0),
`endif
    .pf_req(pf_req_b), .pf_row(pf_row_b),
    .line_start(1'b0), .col_sel(col_sel),
    .square_data(sq_b), .pf_busy(busy_b),
    .pf_done(done_b), .overrun(ovr_b),
    .vga(vga_b)
  );

  // OCM model: rows 0..7 hold {row,col} nibbles.
  logic [7:0] mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) begin
      logic [9:0] a;
      a = 10'(i);
      mem[i] = (i < 64) ? {1'b0, a[5:3], 1'b0, a[2:0]}
                        : a[7:0] ^ 8'hA5;
    end
  end

  always @(posedge clk) begin
    vga_a.vga_readout <= mem[vga_a.vga_addr];
    vga_b.vga_readout <= mem[vga_b.vga_addr];
  end

  int errs = 0;
  int chks = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic bad(string name);
    chks++;
    errs++;
    $display("FAIL %s: got event expected none", name);
  endtask

  int unsigned addr_q[$];
  int unsigned addr_b_q[$];
  int unsigned done_q[$];
  logic [7:0]  sq_q[$];
  logic        look = 1'b0;
  logic        look_d = 1'b0;

  always @(posedge clk) look_d <= look;

  int run_a = 0, last_a = 0;
  int run_b = 0, last_b = 0;

  always @(negedge clk) begin
    chk("vga_we_writein",
        {vga_a.vga_we, vga_b.vga_we,
         |vga_a.vga_writein, |vga_b.vga_writein}, 0);
    if (busy_a) begin
      if (run_a < 8) begin
        if (addr_q.size() == 0) bad("addr_a_unexpected");
        else chk("addr_a", vga_a.vga_addr, addr_q.pop_front());
      end
      run_a++;
    end else if (run_a != 0) begin
      last_a = run_a;
      run_a  = 0;
    end
    if (done_a) begin
      if (done_q.size() == 0) bad("done_a_unexpected");
      else chk("busy_len_a", last_a, done_q.pop_front());
    end
    if (busy_b) begin
      if (run_b < 8) begin
        if (addr_b_q.size() == 0) bad("addr_b_unexpected");
        else chk("addr_b", vga_b.vga_addr, addr_b_q.pop_front());
      end
      run_b++;
    end else if (run_b != 0) begin
      last_b = run_b;
      run_b  = 0;
    end
    if (done_b) chk("busy_len_b", last_b, 9);
    if (look_d) begin
      if (sq_q.size() == 0) bad("square_unexpected");
      else chk("square", sq_a, sq_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(board_idx_t c, logic [7:0] e);
    col_sel = c;
    look    = 1'b1;
    sq_q.push_back(e);
    tick();
    look = 1'b0;
  endtask

  task automatic push_row(int unsigned base, int n);
    for (int i = 0; i < n; i++) addr_q.push_back(base + i);
  endtask

  task automatic swap();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pf_req = 1'b0; pf_req_b = 1'b0;
    line_start = 1'b0; flip = 1'b0;
    pf_row = '0; pf_row_b = '0; col_sel = '0;
    #1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("rst_square", sq_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_overrun", ovr_a, 0);
    chk("rst_addr", vga_a.vga_addr, 0);

    // Row 3 fetch, then swap and read it back.
    push_row(24, 8);
    done_q.push_back(9);
    pf_row = 3'd3; pf_req = 1'b1;
    tick();
    pf_req = 1'b0;
    repeat (10) tick();
    chk("addr_hold", vga_a.vga_addr, 31);
    swap();
    lookup(3'd5, 8'h35);
    for (int c = 0; c < 8; c++) lookup(3'(c), 8'(8'h30 + c));

    // Abort at cycle 4, then an immediate new request.
    push_row(40, 4);
    pf_row = 3'd5; pf_req = 1'b1;
    tick();
    pf_req = 1'b0;
    repeat (3) tick();
    swap();
    chk("abort_overrun", ovr_a, 1);
    chk("abort_busy", busy_a, 0);
    push_row(8, 8);
    done_q.push_back(9);
    pf_row = 3'd1; pf_req = 1'b1;
    tick();
    pf_req = 1'b0;
    repeat (10) tick();
    chk("overrun_sticky", ovr_a, 1);

    // Request and swap together; row 1 is now front.
    push_row(48, 8);
    done_q.push_back(9);
    pf_row = 3'd6; pf_req = 1'b1; line_start = 1'b1;
    tick();
    pf_req = 1'b0; line_start = 1'b0;
    lookup(3'd2, 8'h12);
    lookup(3'd7, 8'h17);
    repeat (8) tick();
    swap();
    lookup(3'd0, 8'h60);
    lookup(3'd7, 8'h67);

    // Address wrap on the high-base instance.
    addr_b_q = '{10'h3FC, 10'h3FD, 10'h3FE, 10'h3FF,
                 10'h000, 10'h001, 10'h002, 10'h003};
    pf_row_b = 3'd0; pf_req_b = 1'b1;
    tick();
    pf_req_b = 1'b0;
    repeat (10) tick();
    chk("b_overrun", ovr_b, 0);

`ifdef OCM_PREFETCH_FLIP_EN
    push_row(56, 8);
    done_q.push_back(9);
    flip = 1'b1; pf_row = 3'd0; pf_req = 1'b1;
    tick();
    pf_req = 1'b0; flip = 1'b0;
    repeat (10) tick();
    swap();
    lookup(3'd0, 8'h77);
    lookup(3'd7, 8'h70);
`endif

    // Reset in the middle of ISSUE.
    push_row(16, 4);
    pf_row = 3'd2; pf_req = 1'b1;
    tick();
    pf_req = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_square", sq_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_overrun", ovr_a, 0);
    chk("mid_rst_addr", vga_a.vga_addr, 0);
    lookup(3'd3, 8'h00);
    lookup(3'd7, 8'h00);
    swap();
    lookup(3'd5, 8'h00);
    repeat (3) tick();

    chk("queues_left",
        addr_q.size() + addr_b_q.size()
        + done_q.size() + sq_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
